// File: rtl/mdu_unit_if.sv
// Controller <-> MDU request/result bundle; controller drives the request side.
// No handshake beyond start/busy: start is a one-cycle strobe, busy blocks new requests.
interface mdu_unit_if;
   logic        start;
   logic [3:0]  mduop;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, mduop, srca, srcb, input busy, hi, lo);
   modport slave  (input start, mduop, srca, srcb, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; MULT/DIV take MULT_CYCLES/DIV_CYCLES busy cycles, MTHI/MTLO none.
// Start is ignored while busy; define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   mdu_unit_if.slave  bus
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   logic [0:0]  state;
   logic [3:0]  cnt;
   req_t        req;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [63:0] res;

   logic signed [63:0] a_s, b_s;
   logic [63:0] prod_s, prod_u;
   logic        div_zero;
   logic [31:0] den_u, den_s, abs_a, abs_b;
   logic [31:0] uq, ur, mag_q, mag_r, sq, sr;

   always_comb begin
      a_s      = {{32{req.a[31]}}, req.a};
      b_s      = {{32{req.b[31]}}, req.b};
      prod_s   = a_s * b_s;
      prod_u   = {32'd0, req.a} * {32'd0, req.b};
      div_zero = (req.b == 32'd0);
      // Divisor forced to 1 on zero so the dividers stay defined; result is overridden below.
      den_u    = div_zero ? 32'd1 : req.b;
      abs_a    = req.a[31] ? (~req.a + 32'd1) : req.a;
      abs_b    = req.b[31] ? (~req.b + 32'd1) : req.b;
      den_s    = div_zero ? 32'd1 : abs_b;
      uq       = req.a / den_u;
      ur       = req.a % den_u;
      mag_q    = abs_a / den_s;
      mag_r    = abs_a % den_s;
      sq       = (req.a[31] ^ req.b[31]) ? (~mag_q + 32'd1) : mag_q;
      sr       = req.a[31] ? (~mag_r + 32'd1) : mag_r;
   end

   always_comb begin
      res = {hi_q, lo_q};
      case (req.op)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV:   res = div_zero ? {req.a, 32'hFFFF_FFFF} : {sr, sq};
         OP_DIVU:  res = div_zero ? {req.a, 32'hFFFF_FFFF} : {ur, uq};
`ifdef MDU_MADD_EN
         // HI/LO are frozen during RUN, so they still hold the accept-edge accumulator.
         OP_MADD:  res = {hi_q, lo_q} + prod_s;
         OP_MADDU: res = {hi_q, lo_q} + prod_u;
         OP_MSUB:  res = {hi_q, lo_q} - prod_s;
         OP_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
         default:  res = {hi_q, lo_q};
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
         req   <= '0;
         hi_q  <= 32'd0;
         lo_q  <= 32'd0;
      end else if (state == S_IDLE) begin
         if (bus.start) begin
            case (bus.mduop)
               OP_MTHI: hi_q <= bus.srca;
               OP_MTLO: lo_q <= bus.srca;
               OP_MULT, OP_MULTU: begin
                  req   <= '{op: bus.mduop, a: bus.srca, b: bus.srcb};
                  cnt   <= MULT_N;
                  state <= S_RUN;
               end
               OP_DIV, OP_DIVU: begin
                  req   <= '{op: bus.mduop, a: bus.srca, b: bus.srcb};
                  cnt   <= DIV_N;
                  state <= S_RUN;
               end
`ifdef MDU_MADD_EN
               OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                  req   <= '{op: bus.mduop, a: bus.srca, b: bus.srcb};
                  cnt   <= MULT_N;
                  state <= S_RUN;
               end
`endif
               default: ;
            endcase
         end
      end else begin
         if (cnt == 4'd1) begin
            {hi_q, lo_q} <= res;
            cnt          <= 4'd0;
            state        <= S_IDLE;
         end else begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   assign bus.busy = (state == S_RUN);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: driver pushes expected HI/LO with due cycle, monitor checks every cycle.
module tb_mdu_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      int          due;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_hi = 0, m_lo = 0;     // model state after all issued ops
   logic [31:0] vis_hi = 0, vis_lo = 0; // model state currently visible
   int          bfrom = 0, bto = -1;

   mdu_unit_if bus();

   mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   function automatic int op_cycles(input logic [3:0] op);
      case (op)
         4'd1, 4'd2: return MC;
         4'd3, 4'd4: return DC;
`ifdef MDU_MADD_EN
         4'd7, 4'd8, 4'd9, 4'd10: return MC;
`endif
         default: return 0;
      endcase
   endfunction

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
      longint      sa, sb;
      logic [63:0] ua, ub, qv, rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         4'd1: return 64'(sa * sb);
         4'd2: return ua * ub;
         4'd3: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            qv = 64'(sa / sb);
            rv = 64'(sa % sb);
            return {rv[31:0], qv[31:0]};
         end
         4'd4: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         4'd7:  return acc + 64'(sa * sb);
         4'd8:  return acc + ua * ub;
         4'd9:  return acc - 64'(sa * sb);
         4'd10: return acc - ua * ub;
         default: return acc;
      endcase
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Called at posedge+1; returns at posedge+1 of the first cycle the unit can accept again.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit wait_done);
      int n;
      bus.start = 1'b1;
      bus.mduop = op;
      bus.srca  = a;
      bus.srcb  = b;
      n = op_cycles(op);
      if (op == 4'd5) begin
         m_hi = a;
         q.push_back('{due: cyc + 1, hi: m_hi, lo: m_lo});
      end else if (op == 4'd6) begin
         m_lo = a;
         q.push_back('{due: cyc + 1, hi: m_hi, lo: m_lo});
      end else if (n > 0) begin
         {m_hi, m_lo} = model(op, a, b, {m_hi, m_lo});
         bfrom = cyc + 1;
         bto   = cyc + n;
         q.push_back('{due: cyc + n + 1, hi: m_hi, lo: m_lo});
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (wait_done) begin
         while (cyc <= bto) begin
            bus.srca  = $urandom;
            bus.srcb  = $urandom;
            bus.mduop = 4'($urandom);
            bus.start = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
         end
         bus.start = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         bus.start = 1'b0;
         bus.mduop = 4'($urandom);
         bus.srca  = $urandom;
         bus.srcb  = $urandom;
         @(posedge clk); #1;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].due <= cyc) begin
         e = q.pop_front();
         vis_hi = e.hi;
         vis_lo = e.lo;
      end
      chk("hi", bus.hi, vis_hi);
      chk("lo", bus.lo, vis_lo);
      chk("busy", {31'd0, bus.busy}, {31'd0, (cyc >= bfrom && cyc <= bto)});
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      bus.start = 1'b0;
      bus.mduop = 4'd0;
      bus.srca  = 32'd0;
      bus.srcb  = 32'd0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
      chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
      chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
      issue(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b1);
      chk("multu_hi", bus.hi, 32'h0000_0002);
      chk("multu_lo", bus.lo, 32'hFFFF_FFFA);
      issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
      chk("div_hi", bus.hi, 32'hFFFF_FFFF);
      chk("div_lo", bus.lo, 32'hFFFF_FFFD);
      issue(4'd4, 32'd7, 32'd0, 1'b1);
      chk("divu0_hi", bus.hi, 32'd7);
      chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      chk("divovf_hi", bus.hi, 32'd0);
      chk("divovf_lo", bus.lo, 32'h8000_0000);
      issue(4'd3, 32'hFFFF_FFF0, 32'd0, 1'b1);
      chk("div0_hi", bus.hi, 32'hFFFF_FFF0);
      chk("div0_lo", bus.lo, 32'hFFFF_FFFF);

      issue(4'd5, 32'h1234_5678, 32'd0, 1'b1);
      chk("mthi_hi", bus.hi, 32'h1234_5678);
      issue(4'd6, 32'h9ABC_DEF0, 32'd0, 1'b1);
      chk("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
      chk("mtlo_hi", bus.hi, 32'h1234_5678);

      // DIV then MULT accepted in the first idle cycle
      issue(4'd3, 32'd100, 32'd7, 1'b1);
      chk("b2b_div_hi", bus.hi, 32'd2);
      chk("b2b_div_lo", bus.lo, 32'd14);
      issue(4'd1, 32'd6, 32'd7, 1'b1);
      chk("b2b_mult_hi", bus.hi, 32'd0);
      chk("b2b_mult_lo", bus.lo, 32'd42);

`ifdef MDU_MADD_EN
      issue(4'd5, 32'd0, 32'd0, 1'b1);
      issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b1);
      issue(4'd8, 32'd1, 32'd1, 1'b1);
      chk("maddu_hi", bus.hi, 32'd1);
      chk("maddu_lo", bus.lo, 32'd0);
      issue(4'd6, 32'd0, 32'd0, 1'b1);
      issue(4'd5, 32'd0, 32'd0, 1'b1);
      issue(4'd9, 32'd1, 32'd1, 1'b1);
      chk("msub_hi", bus.hi, 32'hFFFF_FFFF);
      chk("msub_lo", bus.lo, 32'hFFFF_FFFF);
`else
      issue(4'd5, 32'hAAAA_5555, 32'd0, 1'b1);
      issue(4'd7, 32'd3, 32'd4, 1'b1);
      idle(2);
      chk("op7_hi", bus.hi, 32'hAAAA_5555);
      chk("op7_lo", bus.lo, 32'd42);
      chk("op7_busy", {31'd0, bus.busy}, 32'd0);
`endif

      // Reset in the fourth RUN cycle of a DIV
      issue(4'd3, 32'd1000, 32'd3, 1'b0);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_hi", bus.hi, 32'd0);
      chk("arst_lo", bus.lo, 32'd0);
      chk("arst_busy", {31'd0, bus.busy}, 32'd0);
      q.delete();
      m_hi = 0; m_lo = 0; vis_hi = 0; vis_lo = 0;
      bto = -1;
      @(posedge clk); #1;
      reset = 1'b0;
      idle(15);
      chk("post_rst_hi", bus.hi, 32'd0);
      chk("post_rst_lo", bus.lo, 32'd0);

      for (int i = 0; i < 250; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = rnd_opnd();
         b  = rnd_opnd();
         issue(op, a, b, 1'b1);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit beside the single-cycle ALU in the EX stage. It owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the controller and raises Busy while an operation is in flight.
- The hazard unit stalls any MDU-class instruction while Start or Busy is high.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD-class ops when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle request strobe, qualifies MDUOP.
- MDUOP  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; other codes are treated as NONE.
- SrcA  input  32  rs operand.
- SrcB  input  32  rt operand.
- Busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - HI=0, LO=0, Busy=0, cycle counter=0.
  - Any pending operation is discarded.
- States: IDLE, RUN.
- Accept rule: a request is accepted only in IDLE with Start=1.
  - Start while Busy=1 is ignored. The controller must not issue one.
  - MDUOP is ignored when Start=0.
- MTHI/MTLO: accepted in IDLE with no busy phase.
  - HI (MTHI) or LO (MTLO) takes SrcA at the accepting edge, visible next cycle.
  - Busy stays 0.
- MULT/MULTU/DIV/DIVU:
  - At the accepting edge (cycle t): latch SrcA, SrcB and the op; load counter with N (MULT_CYCLES or DIV_CYCLES); go to RUN.
  - Busy=1 for cycles t+1 .. t+N.
  - At the edge ending cycle t+N: write HI/LO, clear Busy, return to IDLE.
  - New HI/LO are visible in cycle t+N+1.
  - A new Start may be accepted in cycle t+N+1.
- HI/LO hold their old values throughout RUN. Reads during RUN return the pre-operation values.
- Arithmetic:
  - MULT: {HI,LO} = signed(SrcA) * signed(SrcB), full 64-bit result.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
- Boundary cases:
  - Division by zero (DIV or DIVU): LO=32'hFFFFFFFF, HI=SrcA. Full busy latency still applies.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no trap.
  - Operands are latched at acceptance. SrcA/SrcB changes during RUN have no effect.
- Counter: 4 bits, decrements each RUN cycle. RUN exits when the counter reaches 1, so the busy phase is exactly N cycles.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: codes 7-10 are valid and use MULT_CYCLES.
  - MADD: {HI,LO} += signed product.
  - MADDU: {HI,LO} += unsigned product.
  - MSUB: {HI,LO} -= signed product.
  - MSUBU: {HI,LO} -= unsigned product.
  - Accumulation uses the {HI,LO} value present at the accepting edge and wraps modulo 2^64.
- Not defined: codes 7-10 are treated as NONE. No state change, Busy stays 0.

Test Plan:
- Reset pulse during DIV RUN cycle 4 -> Busy=0 and HI=LO=0 immediately (asynchronous), with no later update.
- MULT SrcA=0xFFFFFFFE (-2), SrcB=3 -> Busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV SrcA=0xFFFFFFF9 (-7), SrcB=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on back-to-back cycles -> HI/LO updated one cycle after each, Busy never asserted. Start=1 with MULT pulsed during a DIV RUN -> ignored, DIV result unaffected.
- Start MULT in cycle t+N+1 directly after a DIV completes -> accepted. Busy is continuous except a single 0 cycle at t+N+1, and both results are correct.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU 1*1 -> HI=1, LO=0. MSUB 1*1 from HI=LO=0 -> HI=LO=0xFFFFFFFF. Without the macro, code 7 leaves HI/LO unchanged with Busy=0.
